// File: rtl/vga_timing.sv
// VGA raster timing generator: divides clk by two into a pixel tick, runs the
// horizontal/vertical counters and decodes sync, blanking and frame-start.
module vga_timing #(
    parameter int HACTIVE = 640,
    parameter int HFP     = 16,
    parameter int HSYN    = 96,
    parameter int HBP     = 48,
    parameter int VACTIVE = 480,
    parameter int VFP     = 10,
    parameter int VSYN    = 2,
    parameter int VBP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       vgaclk,
    output logic       hsync,
    output logic       vsync,
    output logic       sync_b,
    output logic       blank_b,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pix_tick,
    output logic       frame_start
);

    localparam int HTOTAL = HACTIVE + HFP + HSYN + HBP;
    localparam int VTOTAL = VACTIVE + VFP + VSYN + VBP;

    localparam logic [9:0] H_LAST       = 10'(HTOTAL - 1);
    localparam logic [9:0] H_ACT        = 10'(HACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(HACTIVE + HFP);
    localparam logic [9:0] H_SYNC_END   = 10'(HACTIVE + HFP + HSYN);
    localparam logic [9:0] V_LAST       = 10'(VTOTAL - 1);
    localparam logic [9:0] V_ACT        = 10'(VACTIVE);
    localparam logic [9:0] V_SYNC_START = 10'(VACTIVE + VFP);
    localparam logic [9:0] V_SYNC_END   = 10'(VACTIVE + VFP + VSYN);

    logic       phase_q, phase_d;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic       frame_start_q, frame_start_d;
    logic       h_last, v_last;

    assign h_last = (hcnt_q == H_LAST);
    assign v_last = (vcnt_q == V_LAST);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        phase_d       = ~phase_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        frame_start_d = 1'b0;
        if (phase_q) begin
            if (h_last) begin
                hcnt_d = '0;
                vcnt_d = v_last ? '0 : vcnt_q + 10'd1;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
            // Registered so the pulse lands in the cycle right after the (0,0) wrap.
            frame_start_d = h_last && v_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q       <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            frame_start_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            phase_q       <= phase_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vgaclk      = phase_q;
    assign pix_tick    = phase_q;
    assign x           = hcnt_q;
    assign y           = vcnt_q;
    assign hsync       = !((hcnt_q >= H_SYNC_START) && (hcnt_q < H_SYNC_END));
    assign vsync       = !((vcnt_q >= V_SYNC_START) && (vcnt_q < V_SYNC_END));
    assign blank_b     = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    assign sync_b      = 1'b0;
    assign frame_start = frame_start_q;

endmodule
